param_bound_flasher: RTL

Parametrised bound-flasher lamp controller: drives a `WIDTH`-lamp thermometer bar through a three-bound up/down sweep sequence. The sequence starts on `flick`, supports flick-driven kickback at the two intermediate bounds, and optionally ends with a full-bar blink burst. Standalone leaf block: the control FSM and the level counter are internal, and the lamp decode is combinational from registered state.

---
 rtl/param_bound_flasher.sv | 116 +++++++++++
 1 files changed

// File: rtl/param_bound_flasher.sv
// param_bound_flasher: three-bound up/down thermometer lamp sweep with flick kickback; `PARAM_BOUND_FLASHER_BLINK_EN adds an end-of-sequence blink burst.
module param_bound_flasher #(
  parameter int WIDTH       = 16,
  parameter int BOUND1      = 5,
  parameter int BOUND2      = 10,
  parameter int BLINK_COUNT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flick,
  output logic [WIDTH-1:0] light,
  output logic             busy
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam logic [LW-1:0] B1 = LW'(BOUND1);
  localparam logic [LW-1:0] B2 = LW'(BOUND2);
  localparam logic [LW-1:0] WD = LW'(WIDTH);
  if (WIDTH < 3 || BOUND1 < 1 || BOUND1 >= BOUND2 || BOUND2 >= WIDTH || BLINK_COUNT < 1) begin : g_bad_params
    $error("param_bound_flasher: illegal parameter set");
  end
  typedef enum logic [2:0] {IDLE, UP1, DOWN1, UP2, DOWN2, UP3, DOWN3, BLINK} state_t;
  state_t state, state_nx;
  logic [LW-1:0] level, level_nx, inc, dec;
  logic [WIDTH-1:0] therm;
  assign inc = level + 1'b1;
  assign dec = level - 1'b1;
  assign busy = state != IDLE;
`ifdef PARAM_BOUND_FLASHER_BLINK_EN
  localparam int CW = $clog2(2 * BLINK_COUNT + 1);
  logic [CW-1:0] blink_cnt, blink_cnt_nx;
  logic phase, phase_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nx;
      phase     <= phase_nx;
    end
  assign light = (state == BLINK) ? {WIDTH{phase}} : therm;
`else
  assign light = therm;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      level <= '0;
    end else begin
      state <= state_nx;
      level <= level_nx;
    end
  always_comb begin
    therm = '0;
    for (int i = 0; i < WIDTH; i++) therm[i] = int'(level) > i;
  end
  // Kickback checks the current level and wins over the normal step.
  always_comb begin
    state_nx = state;
    level_nx = level;
`ifdef PARAM_BOUND_FLASHER_BLINK_EN
    blink_cnt_nx = blink_cnt;
    phase_nx     = phase;
`endif
    case (state)
      IDLE: begin
        level_nx = flick ? LW'(1) : '0;
        state_nx = flick ? UP1 : IDLE;
      end
      UP1: begin
        level_nx = inc;
        state_nx = (inc == B1) ? DOWN1 : UP1;
      end
      DOWN1: begin
        level_nx = dec;
        state_nx = (dec == '0) ? UP2 : DOWN1;
      end
      UP2: begin
        level_nx = (level == B1 && flick) ? B1 - 1'b1 : inc;
        state_nx = (level == B1 && flick) ? DOWN1 : (inc == B2) ? DOWN2 : UP2;
      end
      DOWN2: begin
        level_nx = dec;
        state_nx = (dec == B1) ? UP3 : DOWN2;
      end
      UP3: begin
        level_nx = (level == B2 && flick) ? B2 - 1'b1 : inc;
        state_nx = (level == B2 && flick) ? DOWN2 : (inc == WD) ? DOWN3 : UP3;
      end
      DOWN3: begin
        level_nx = dec;
`ifdef PARAM_BOUND_FLASHER_BLINK_EN
        state_nx = (dec == '0) ? BLINK : DOWN3;
`else
        state_nx = (dec == '0) ? IDLE : DOWN3;
`endif
      end
`ifdef PARAM_BOUND_FLASHER_BLINK_EN
      BLINK: begin
        level_nx = '0;
        if (blink_cnt == CW'(2 * BLINK_COUNT - 1)) begin
          state_nx     = IDLE;
          blink_cnt_nx = '0;
          phase_nx     = 1'b0;
        end else begin
          blink_cnt_nx = blink_cnt + 1'b1;
          phase_nx     = ~phase;
        end
      end
`endif
      default: begin
        state_nx = IDLE;
        level_nx = '0;
      end
    endcase
  end
endmodule
